// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - write/read handshake bundle between the router FSM stage and one output FIFO
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic             read_enb;
    logic             soft_reset;
    logic [WIDTH-1:0] data_in;
    logic             lfd_state;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;

    modport master (
        output write_enb, read_enb, soft_reset, data_in, lfd_state,
        input  data_out, empty, full
    );

    modport slave (
        input  write_enb, read_enb, soft_reset, data_in, lfd_state,
        output data_out, empty, full
    );
endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-channel packet FIFO with header marker and remaining-byte counter
// Optional: FIFO_TRISTATE_OUT_EN drives data_out to Z (instead of 0) on flush and after a packet drains.
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4
) (
    input  logic          clock,
    input  logic          resetn,
    router_fifo_if.slave  bus
);
    logic [WIDTH:0]   mem [DEPTH];
    logic [AWIDTH:0]  wr_ptr;
    logic [AWIDTH:0]  rd_ptr;
    logic [5:0]       count;
    logic             drained;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH:0]   rd_entry;
    logic             do_wr;
    logic             do_rd;
    logic             rd_hdr;

    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                       (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);

    assign do_wr    = bus.write_enb && !bus.full;
    assign do_rd    = bus.read_enb && !bus.empty;
    assign rd_entry = mem[rd_ptr[AWIDTH-1:0]];
    assign rd_hdr   = rd_entry[WIDTH];

`ifdef FIFO_TRISTATE_OUT_EN
    logic hiz;
    assign bus.data_out = hiz ? {WIDTH{1'bz}} : data_q;
`else
    assign bus.data_out = data_q;
`endif

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.soft_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr[AWIDTH-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            drained <= 1'b0;
            data_q  <= '0;
`ifdef FIFO_TRISTATE_OUT_EN
            hiz     <= 1'b0;
`endif
        end else if (bus.soft_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            drained <= 1'b0;
            data_q  <= '0;
`ifdef FIFO_TRISTATE_OUT_EN
            hiz     <= 1'b1;
`endif
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                data_q <= rd_entry[WIDTH-1:0];
`ifdef FIFO_TRISTATE_OUT_EN
                hiz    <= 1'b0;
`endif
                // Header byte carries payload length in its upper six bits; +1 covers parity.
                if (rd_hdr) begin
                    count   <= rd_entry[WIDTH-1:2] + 6'd1;
                    drained <= 1'b0;
                end else begin
                    if (count != 6'd0) count <= count - 6'd1;
                    drained <= (count == 6'd1);
                end
            end else if (drained) begin
                // Last byte of the packet was shown for one cycle; now release the output.
                drained <= 1'b0;
                data_q  <= '0;
`ifdef FIFO_TRISTATE_OUT_EN
                hiz     <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed and randomized checks of router_fifo against a queue-based packet model
module tb_router_fifo;
    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo #(.WIDTH(8), .DEPTH(16), .AWIDTH(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] m_q[$];
    logic [5:0] m_cnt;
    logic [7:0] m_do;
    logic       m_drained;
    logic [7:0] idle_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".empty"}, {31'd0, bus.empty}, {31'd0, (m_q.size() == 0)});
        chk({tag, ".full"}, {31'd0, bus.full}, {31'd0, (m_q.size() == 16)});
        chk({tag, ".data_out"}, {24'd0, bus.data_out}, {24'd0, m_do});
        chk({tag, ".count"}, {26'd0, dut.count}, {26'd0, m_cnt});
    endtask

    task automatic model_clear(input logic [7:0] dout);
        m_q.delete();
        m_cnt     = 6'd0;
        m_drained = 1'b0;
        m_do      = dout;
    endtask

    task automatic step(input logic we, input logic re, input logic sr,
                        input logic [7:0] din, input logic lfd, input string tag);
        logic       wr_ok;
        logic       rd_ok;
        logic [8:0] e;
        logic [5:0] prev;
        bus.write_enb  = we;
        bus.read_enb   = re;
        bus.soft_reset = sr;
        bus.data_in    = din;
        bus.lfd_state  = lfd;
        @(posedge clock);
        #1;
        if (sr) begin
            model_clear(idle_val);
        end else begin
            wr_ok = we && (m_q.size() < 16);
            rd_ok = re && (m_q.size() > 0);
            if (rd_ok) begin
                e    = m_q.pop_front();
                prev = m_cnt;
                m_do = e[7:0];
                if (e[8]) begin
                    m_cnt     = e[7:2] + 6'd1;
                    m_drained = 1'b0;
                end else begin
                    if (m_cnt != 0) m_cnt = m_cnt - 6'd1;
                    m_drained = (prev == 6'd1);
                end
            end else if (m_drained) begin
                m_drained = 1'b0;
                m_do      = idle_val;
            end
            if (wr_ok) m_q.push_back({lfd, din});
        end
        bus.write_enb  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.soft_reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
`ifdef FIFO_TRISTATE_OUT_EN
        idle_val = 8'hzz;
`else
        idle_val = 8'h00;
`endif
        bus.write_enb  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.soft_reset = 1'b0;
        bus.data_in    = 8'h00;
        bus.lfd_state  = 1'b0;

        // Reset pulse
        @(posedge clock);
        #1;
        resetn = 1'b0;
        model_clear(8'h00);
        check_all("reset");

        // Fill past capacity with one 19-byte packet
        step(1'b1, 1'b0, 1'b0, 8'h4E, 1'b1, "fill_hdr");
        for (int i = 1; i <= 20; i++)
            step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 1'b0, "fill");
        chk("fill.occupancy", {31'd0, bus.full}, 32'd1);

        // Drain: header first, then payload in order, then reads on empty
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "drain");
        chk("drain.count_left", {26'd0, dut.count}, 32'd5);

        // Concurrent read/write at full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 1'b0, "refill");
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, "rw_full");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "to_half");
        chk("half.level", {31'd0, bus.empty}, 32'd0);

        // Concurrent read/write at half occupancy keeps order
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i), 1'b0, "rw_half");
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "half_drain");

        // Soft reset with 5 entries stored, a request in the same cycle is ignored
        step(1'b1, 1'b0, 1'b0, 8'h4E, 1'b1, "sr_fill");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 1'b0, "sr_fill");
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, "soft_reset");
        step(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, "post_sr_wr");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "post_sr_rd");

        // Async reset mid-packet takes effect without a clock edge
        step(1'b1, 1'b0, 1'b0, 8'h0C, 1'b1, "mid_fill");
        step(1'b1, 1'b0, 1'b0, 8'h01, 1'b0, "mid_fill");
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "mid_rd");
        #2;
        resetn = 1'b1;
        #1;
        model_clear(8'h00);
        check_all("async_reset");
        @(posedge clock);
        #1;
        resetn = 1'b0;

        // Wrap-around: 3 rounds of 12 writes then 12 reads
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 8'(r * 12 + i), 1'b0, "wrap_wr");
            for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "wrap_rd");
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic lfd;
            lfd = ($urandom_range(0, 99) < 10);
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 199) < 2), 8'($urandom), lfd, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Synchronous single-clock FIFO used in the router datapath, one instance per output channel.
- Buffers packet bytes (header, payload, parity) between the register/FSM stage and the destination read port.
- Each entry stores the data byte plus a header-marker bit taken from lfd_state.
- An internal packet byte counter, loaded when a header is read out, tracks the remaining bytes of the current packet.

Parameters:
- WIDTH, 8, data byte width; each entry is WIDTH+1 bits including the header-marker bit.
- DEPTH, 16, number of entries; power of two.
- AWIDTH, 4, address width (log2 DEPTH); pointers are AWIDTH+1 bits.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- resetn  in  1  asynchronous reset, active-high (level 1 resets), despite the port name.
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- soft_reset  in  1  synchronous flush, active-high.
- data_in  in  WIDTH  byte to write.
- lfd_state  in  1  1 = data_in is a packet header; stored as the entry's marker bit.
- data_out  out  WIDTH  registered read data.
- empty  out  1  combinational, 1 when no entries are stored.
- full  out  1  combinational, 1 when DEPTH entries are stored.

Behaviour:
- Async reset (resetn=1): clears write and read pointers, clears the packet count, clears all memory entries, and sets data_out=0.
  - After reset: empty=1, full=0.
- Soft reset: when soft_reset=1 at a clock edge, it has the same effect as reset, and read/write requests in that cycle are ignored.
- Pointers: wr_ptr and rd_ptr are AWIDTH+1 bits; the lower AWIDTH bits address memory.
  - empty = (wr_ptr == rd_ptr).
  - full = (lower bits equal) AND (MSBs differ).
  - Pointers wrap naturally modulo 2*DEPTH.
- Write: on an edge with write_enb=1 and full=0, mem[wr_ptr] <= {lfd_state, data_in}, then wr_ptr increments.
  - A write while full is dropped silently: no pointer change, no overwrite.
- Read: on an edge with read_enb=1 and empty=0, data_out <= mem[rd_ptr][WIDTH-1:0], then rd_ptr increments.
  - One-cycle latency from the read edge.
  - A read while empty is ignored; data_out holds.
- Packet count (6 bits):
  - When the entry being read has marker bit 1, count <= data[7:2] + 1 (payload length + parity).
  - Otherwise, on each valid read with count != 0, count <= count - 1.
  - No change without a read.
- data_out holds its last value between reads, except as stated under Optional Feature.
- Simultaneous read and write:
  - Both take effect in the same cycle, and the occupancy is unchanged.
  - When full, only the read takes effect: full is evaluated before the edge, so the write is dropped.
  - When empty, only the write takes effect; there is no fall-through.
- full and empty update combinationally from the new pointers, i.e. in the same cycle after the edge.
- Reset asserted mid-packet discards all stored data and the count immediately.

Optional Feature:
- Macro: FIFO_TRISTATE_OUT_EN.
- Defined:
  - data_out is driven to high-impedance (all Z) while soft_reset is applied.
  - data_out also goes to Z on the edge after the packet count reaches 0 following a non-header read (the packet is fully drained).
  - data_out stays Z until the next valid read.
- Undefined: data_out is 0 in those cases instead of Z; all other behaviour is identical.

Test Plan:
- Reset: pulse resetn=1 for one cycle, then 0 -> empty=1, full=0, data_out=0x00.
- Fill past capacity:
  - Stimulus: header 0x4E (payload length 19, address 2) with lfd_state=1, then 19 payload bytes and one parity byte with lfd_state=0, write_enb held high, no reads.
  - Response: full=1 after the 16th write edge; bytes 17-21 are dropped.
- Drain:
  - Stimulus: assert read_enb.
  - Response: data_out=0x4E one edge later and count=20; the following 15 reads return the first 15 payload bytes in order; empty=1 after the 16th read; further reads leave data_out unchanged (or Z when FIFO_TRISTATE_OUT_EN is defined and count reached 0).
- Concurrent read and write:
  - At full, with write_enb=read_enb=1 for one cycle: one entry is read, the write is dropped, full=0.
  - At half occupancy (8 entries): occupancy stays 8 and the data order is preserved.
- Soft reset: with 5 entries stored, assert soft_reset for one cycle -> empty=1, count=0, data_out=0 (Z with the feature), and the next write/read returns the new data.
- Wrap-around: 3 rounds of 12 writes followed by 12 reads with incrementing data -> every byte reads back in order, and full and empty remain correct across pointer wrap.
